// File: rtl/calc_result_bcd_if.sv
// Handshake bundle between the calculator datapath, the BCD formatter and the readout stage.
interface calc_result_bcd_if #(
    parameter int RESULT_W = 9,
    parameter int NDIG     = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [RESULT_W-1:0]   in_result;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_neg;
    logic [4*NDIG-1:0]     out_bcd;

    modport master (
        output in_valid, in_result, out_ready,
        input  in_ready, out_valid, out_neg, out_bcd
    );

    modport slave (
        input  in_valid, in_result, out_ready,
        output in_ready, out_valid, out_neg, out_bcd
    );
endinterface

// File: rtl/calc_result_bcd.sv
// Signed binary result -> sign-magnitude BCD, one double-dabble step per clock.
// The formatted result is held until the downstream stage accepts it.
module calc_result_bcd #(
    parameter int RESULT_W = 9,
    parameter int NDIG     = 3
) (
    input  logic              clk,
    input  logic              rst,
    calc_result_bcd_if.slave  bus
);
    localparam int CNT_W = $clog2(RESULT_W + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t               r_state;
    logic [4*NDIG-1:0]    r_acc;
    logic [RESULT_W-1:0]  r_mag;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg_cap;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_out_neg;
    logic [4*NDIG-1:0]    r_out_bcd;

    logic [4*NDIG-1:0]    w_adj;
    logic [4*NDIG-1:0]    w_next_acc;
    logic [RESULT_W-1:0]  w_abs;

    always_comb begin
        w_adj = r_acc;
        for (int unsigned d = 0; d < NDIG; d++) begin
            if (r_acc[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
        end
    end

    // Top bit of the adjusted accumulator is always shifted out; the digit bound keeps it zero.
    assign w_next_acc = (w_adj << 1) | (4*NDIG)'(r_mag[RESULT_W-1]);
    assign w_abs      = bus.in_result[RESULT_W-1] ? ((~bus.in_result) + RESULT_W'(1))
                                                  : bus.in_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_mag       <= '0;
            r_cnt       <= '0;
            r_neg_cap   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_neg   <= 1'b0;
            r_out_bcd   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_neg_cap  <= bus.in_result[RESULT_W-1];
                        r_mag      <= w_abs;
                        r_acc      <= '0;
                        r_cnt      <= CNT_W'(RESULT_W);
                        r_in_ready <= 1'b0;
                        r_state    <= CONV;
                    end
                end
                CONV: begin
                    r_acc <= w_next_acc;
                    r_mag <= r_mag << 1;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_out_bcd   <= w_next_acc;
                        r_out_neg   <= r_neg_cap;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_neg   = r_out_neg;
    assign bus.out_bcd   = r_out_bcd;
endmodule

// File: tb/tb_calc_result_bcd.sv
// Directed bench for calc_result_bcd: conversion values, latency, backpressure, abort and back-to-back flow.
module tb_calc_result_bcd;
    localparam int RW  = 9;
    localparam int ND  = 3;
    localparam int LAT = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    calc_result_bcd_if #(.RESULT_W(RW), .NDIG(ND)) bus ();

    calc_result_bcd #(.RESULT_W(RW), .NDIG(ND)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents val and returns just after the edge that accepted it; in_valid is left high.
    task automatic accept(input string tag, input logic [RW-1:0] val);
        int w;
        w = 0;
        bus.in_result = val;
        bus.in_valid  = 1'b1;
        while (!bus.in_ready && w < 50) begin
            tick();
            w++;
        end
        check({tag, "_accept_timeout"}, 32'(w < 50), 32'd1);
        tick();
    endtask

    task automatic wait_out(output int lat, output int busy);
        lat  = 0;
        busy = 0;
        while (!bus.out_valid && lat < 50) begin
            if (bus.in_ready) busy++;
            tick();
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [RW-1:0] val, input logic neg,
                       input logic [11:0] bcd, input int hold);
        int lat, busy;
        bus.out_ready = (hold == 0);
        accept(tag, val);
        bus.in_valid  = 1'b0;
        bus.in_result = ~val;
        wait_out(lat, busy);
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_ready_busy"}, 32'(busy), 32'd0);
        check({tag, "_neg"}, 32'(bus.out_neg), 32'(neg));
        check({tag, "_bcd"}, 32'(bus.out_bcd), 32'(bcd));
        check({tag, "_ready_done"}, 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold"}, {18'd0, bus.in_ready, bus.out_valid, bus.out_neg, bus.out_bcd},
                  {18'd0, 1'b0, 1'b1, neg, bcd});
        end
        bus.out_ready = 1'b1;
        tick();
        check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int lat, busy, seen;
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_state", {18'd0, bus.in_ready, bus.out_valid, bus.out_neg, bus.out_bcd},
              {18'd0, 1'b1, 1'b0, 1'b0, 12'h000});

        bus.out_ready = 1'b1;
        tick();
        check("idle_ignores_out_ready", {30'd0, bus.in_ready, bus.out_valid}, {30'd0, 1'b1, 1'b0});

        run("zero", 9'h000, 1'b0, 12'h000, 0);
        run("p255", 9'h0FF, 1'b0, 12'h255, 0);
        run("n256", 9'h100, 1'b1, 12'h256, 0);
        run("n1",   9'h1FF, 1'b1, 12'h001, 0);
        run("n137", 9'h177, 1'b1, 12'h137, 6);

        // Abort: reset sampled at the 4th CONV edge
        bus.out_ready = 1'b1;
        accept("abort", 9'h063);
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_state", {18'd0, bus.in_ready, bus.out_valid, bus.out_neg, bus.out_bcd},
              {18'd0, 1'b1, 1'b0, 1'b0, 12'h000});
        seen = 0;
        repeat (20) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("abort_no_output", 32'(seen), 32'd0);
        run("p42", 9'h02A, 1'b0, 12'h042, 0);

        // Back-to-back with in_valid held high
        bus.out_ready = 1'b1;
        accept("b2b_first", 9'h064);
        bus.in_result = 9'h1B5;
        wait_out(lat, busy);
        check("b2b1_latency", 32'(lat), 32'(LAT));
        check("b2b1_ready_busy", 32'(busy), 32'd0);
        check("b2b1_result", {19'd0, bus.out_neg, bus.out_bcd}, {19'd0, 1'b0, 12'h100});
        tick();
        check("b2b_gap", {30'd0, bus.in_ready, bus.out_valid}, {30'd0, 1'b1, 1'b0});
        tick();
        bus.in_valid = 1'b0;
        check("b2b2_accepted", 32'(bus.in_ready), 32'd0);
        wait_out(lat, busy);
        check("b2b2_latency", 32'(lat), 32'(LAT));
        check("b2b2_ready_busy", 32'(busy), 32'd0);
        check("b2b2_result", {19'd0, bus.out_neg, bus.out_bcd}, {19'd0, 1'b1, 12'h075});
        tick();
        check("b2b2_valid_drop", 32'(bus.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/calc_result_bcd.md
Name: calc_result_bcd

Overview:
- Consumer end of the calculator datapath: accepts a signed binary result over a valid/ready handshake.
- Converts it to sign-magnitude BCD (sign flag plus NDIG decimal digits) for the display/readout stage.
- Conversion is sequential shift-and-add-3 (double dabble), one bit per clock.
- Holds the formatted result until the downstream stage accepts it.

Parameters:
- RESULT_W, 9, width of the signed two's-complement input result.
- NDIG, 3, number of BCD output digits; must satisfy 10^NDIG > 2^(RESULT_W-1).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_result holds a result to convert
- in_ready  output  1  block can accept a result this cycle
- in_result  input  RESULT_W  signed two's-complement result
- out_valid  output  1  out_neg/out_bcd hold a completed conversion
- out_ready  input  1  downstream accepts the output this cycle
- out_neg  output  1  1 = result was negative
- out_bcd  output  4*NDIG  BCD magnitude; digit 0 (ones) in bits [3:0], most significant digit in the top nibble

Behaviour:
- One clock; reset is synchronous and active-high.
- rst high at an edge forces: state IDLE; in_ready=1 after that edge; out_valid=0; out_neg=0; out_bcd=0; internal shift and count registers cleared.
- rst overrides everything, including in_valid and out_ready at the same edge.
- Reset during CONV or DONE aborts the operation. The result is discarded and is never presented.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: capture neg=in_result[RESULT_W-1] and mag=|in_result| as a RESULT_W-bit unsigned value. The most negative input maps correctly (-256 -> 256).
  - Also on that edge: clear the BCD accumulator, load the bit counter with RESULT_W, go to CONV.
- State CONV:
  - in_ready=0, out_valid=0.
  - Each edge: add 3 to every accumulator digit >= 5, then shift {accumulator, mag} left by one; decrement the counter.
  - After the edge where the counter reaches 0, go to DONE.
  - Exactly RESULT_W CONV edges per conversion.
- State DONE:
  - out_valid=1, in_ready=0.
  - out_neg and out_bcd are registered and stable for the whole DONE interval.
  - On an edge with out_ready=1: go to IDLE; out_valid drops the next cycle. out_neg/out_bcd keep their last values (don't-care once out_valid=0).
- Latency: acceptance at edge N -> out_valid=1 in the cycle after edge N+RESULT_W (9 cycles at defaults).
- Minimum period between acceptances is RESULT_W+2 cycles, given out_ready already high.
- No overlap: a new input is never accepted while CONV or DONE is active.
- in_result is sampled only at the acceptance edge; later changes have no effect.
- Zero input gives out_neg=0, all digits 0 (no negative zero).
- Every output digit is a legal BCD value 0..9 for all inputs.
- out_ready asserted outside DONE is ignored.

Test Plan:
- rst held 2 cycles, then released -> in_ready=1, out_valid=0, out_bcd=0, out_neg=0.
- in_result=0, out_ready=1 -> out_valid exactly 9 cycles after acceptance; out_neg=0, out_bcd=0x000.
- in_result=255 -> out_neg=0, out_bcd=0x255. in_result=-256 -> out_neg=1, out_bcd=0x256. in_result=-1 -> out_neg=1, out_bcd=0x001.
- Backpressure: in_result=-137, out_ready=0 for 6 cycles after out_valid rises:
  - out_neg=1, out_bcd=0x137 stable throughout; in_ready=0.
  - out_ready=1 -> out_valid falls the next cycle; in_ready=1.
- Reset mid-operation: accept 99, assert rst on the 4th CONV cycle:
  - IDLE state, out_valid never asserts for that input.
  - A following input of 42 yields out_bcd=0x042 with normal latency.
- Back-to-back: in_valid held high with 100, then -75; out_ready=1:
  - Two outputs in order (0x100/neg=0, then 0x075/neg=1).
  - Second acceptance occurs only after the first output handshake; in_ready low during CONV/DONE.
